// File: rtl/ddr3_app_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the DDR3 application-port arbiter.
package ddr3_app_arbiter_pkg;

  localparam logic [2:0]  CMD_WR  = 3'b000;
  localparam logic [2:0]  CMD_RD  = 3'b001;
  localparam int unsigned APP_AW  = 27;
  localparam int unsigned APP_DW  = 128;
  localparam int unsigned BURST_W = 6;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWdata,
    StRdata
  } state_e;

  // Round-robin successor of a requester index, wrapping at nreq.
  function automatic logic [1:0] next_idx(input logic [1:0] idx, input int unsigned nreq);
    if (32'(idx) + 32'd1 >= nreq) return 2'd0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/ddr3_app_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr, with wrap.
module ddr3_app_arbiter_rr #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!found && req[i] && (((int'(rr_ptr) + k) % int'(NREQ)) == i)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = 2'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Shares one DDR3 controller app port between NREQ requesters, one transaction at a time,
// round-robin, with read-data routing and a read watchdog.
module ddr3_app_arbiter
  import ddr3_app_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = APP_AW,
  parameter int unsigned DW      = APP_DW,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    init_calib_complete,
  input  logic [NREQ-1:0]         req_cmd_en,
  input  logic [3*NREQ-1:0]       req_cmd,
  input  logic [AW*NREQ-1:0]      req_addr,
  input  logic [6*NREQ-1:0]       req_burst_number,
  output logic [NREQ-1:0]         req_cmd_rdy,
  input  logic [NREQ-1:0]         req_wdata_en,
  input  logic [DW*NREQ-1:0]      req_wdata,
  output logic [NREQ-1:0]         req_wdata_rdy,
  output logic [NREQ-1:0]         req_rdata_valid,
  output logic [NREQ-1:0]         req_rdata_end,
  output logic [DW-1:0]           req_rdata,
  output logic                    app_cmd_en,
  output logic [2:0]              app_cmd,
  output logic [AW-1:0]           app_addr,
  output logic [BURST_W-1:0]      app_burst_number,
  input  logic                    app_cmd_rdy,
  output logic                    app_wdata_en,
  output logic                    app_wdata_end,
  output logic [DW-1:0]           app_wdata,
  input  logic                    app_wdata_rdy,
  input  logic                    app_rdata_valid,
  input  logic                    app_rdata_end,
  input  logic [DW-1:0]           app_rdata,
  output logic                    busy,
  output logic [1:0]              owner,
  output logic                    err
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [1:0]           owner_q, owner_d;
  logic [2:0]           cmd_q, cmd_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 cmd_en_q, cmd_en_d;
  logic [BURST_W-1:0]   beat_q, beat_d;
  logic [WdW-1:0]       wd_q, wd_d;
  logic                 err_q, err_d;

  logic [NREQ-1:0]      grant;
  logic [1:0]           grant_idx;
  logic                 accept;
  logic [2:0]           sel_cmd;
  logic [AW-1:0]        sel_addr;
  logic [BURST_W-1:0]   sel_burst;
  logic                 wr_sel, rd_sel;

  ddr3_app_arbiter_rr #(
    .NREQ (NREQ)
  ) u_rr (
    .req       (req_cmd_en),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept = (state_q == StIdle) && init_calib_complete && (|req_cmd_en);
  assign wr_sel = (state_q == StWdata);
  assign rd_sel = (state_q == StRdata);

  always_comb begin
    sel_cmd   = '0;
    sel_addr  = '0;
    sel_burst = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_idx == 2'(i)) begin
        sel_cmd   = req_cmd[3*i +: 3];
        sel_addr  = req_addr[AW*i +: AW];
        sel_burst = req_burst_number[6*i +: 6];
      end
    end
  end

  // Data-path muxes stay combinational so write and read beats pass with no added latency.
  always_comb begin
    req_cmd_rdy     = accept ? grant : '0;
    req_wdata_rdy   = '0;
    req_rdata_valid = '0;
    req_rdata_end   = '0;
    req_rdata       = app_rdata;
    app_wdata_en    = 1'b0;
    app_wdata       = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (owner_q == 2'(i)) begin
        req_wdata_rdy[i]   = wr_sel && app_wdata_rdy;
        req_rdata_valid[i] = rd_sel && app_rdata_valid;
        req_rdata_end[i]   = rd_sel && app_rdata_end;
        if (wr_sel) begin
          app_wdata_en = req_wdata_en[i];
          app_wdata    = req_wdata[DW*i +: DW];
        end
      end
    end
    app_wdata_end = app_wdata_en && (beat_q == burst_q);
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    cmd_en_d = cmd_en_q;
    beat_d   = beat_q;
    wd_d     = wd_q;
    // Read beats with no transaction waiting for them are dropped and flagged.
    err_d    = app_rdata_valid && (state_q != StRdata);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = grant_idx;
          cmd_d   = sel_cmd;
          addr_d  = sel_addr;
          burst_d = sel_burst;
          if (sel_cmd == CMD_WR || sel_cmd == CMD_RD) begin
            state_d  = StCmd;
            cmd_en_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            rr_ptr_d = next_idx(grant_idx, NREQ);
          end
        end
      end
      StCmd: begin
        if (app_cmd_rdy) begin
          cmd_en_d = 1'b0;
          beat_d   = '0;
          wd_d     = '0;
          state_d  = (cmd_q == CMD_WR) ? StWdata : StRdata;
        end
      end
      StWdata: begin
        if (app_wdata_en && app_wdata_rdy) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == burst_q) begin
            state_d  = StIdle;
            rr_ptr_d = next_idx(owner_q, NREQ);
          end
        end
      end
      StRdata: begin
        // Completion counts valid beats; the controller's rdata_end is only forwarded.
        if (app_rdata_valid) begin
          wd_d   = '0;
          beat_d = beat_q + 1'b1;
          if (beat_q == burst_q) begin
            state_d  = StIdle;
            rr_ptr_d = next_idx(owner_q, NREQ);
          end
        end else if (TIMEOUT != 0 && wd_q == WdLast) begin
          err_d    = 1'b1;
          state_d  = StIdle;
          rr_ptr_d = next_idx(owner_q, NREQ);
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      burst_q  <= '0;
      cmd_en_q <= 1'b0;
      beat_q   <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      cmd_en_q <= cmd_en_d;
      beat_q   <= beat_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end

  assign app_cmd_en       = cmd_en_q;
  assign app_cmd          = cmd_q;
  assign app_addr         = addr_q;
  assign app_burst_number = burst_q;
  assign busy             = (state_q != StIdle);
  assign owner            = owner_q;
  assign err              = err_q;

endmodule
